// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry block: scan FSM states,
// special key codes and the 4x4 matrix decode table.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    ACCEPT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Matrix position to key code; A..D map to 10..13.
  function automatic logic [3:0] key_decode(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd10;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd11;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd12;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'd13;
    endcase
    return code;
  endfunction

  // Index of the (single) low bit of an active-low one-cold vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 active-low keypad: row synchronizer, step
// divider, press/release debounce FSM and key decode. Emits a one-cycle
// press strobe (high exactly while the FSM is in ACCEPT) with its code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       press_o,
  output logic [3:0] code_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  scan_state_e      state_q;
  logic [3:0]       col_q;
  logic [3:0]       pat_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic [3:0]       code_q;

  logic             sample;
  logic             single_low;
  logic [3:0]       col_next;

  assign sample     = (div_q == DIV_LAST);
  assign single_low = $onehot(~row_s2_q);
  assign col_next   = {col_q[2:0], col_q[3]};

  // Two-flop synchronizer on the asynchronous keypad rows.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
    end else begin
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
    end
  end

  // Free-running column-step divider; its last count is the sample point.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else if (sample) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Scan / debounce / accept / release FSM with registered col and strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SCAN;
      col_q   <= 4'b1110;
      pat_q   <= 4'b1111;
      cnt_q   <= '0;
      press_q <= 1'b0;
      code_q  <= 4'd0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (sample) begin
            if (single_low) begin
              state_q <= DEBOUNCE;
              pat_q   <= row_s2_q;
              cnt_q   <= CNT_W'(1);
            end else begin
              col_q <= col_next;
            end
          end
        end
        DEBOUNCE: begin
          if (sample) begin
            if (row_s2_q == pat_q) begin
              if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                state_q <= ACCEPT;
                press_q <= 1'b1;
                code_q  <= key_decode(low_index(pat_q), low_index(col_q));
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              state_q <= SCAN;
              col_q   <= col_next;
            end
          end
        end
        ACCEPT: begin
          state_q <= WAIT_RELEASE;
          cnt_q   <= '0;
        end
        WAIT_RELEASE: begin
          if (sample) begin
            if (row_s2_q == 4'b1111) begin
              if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                state_q <= SCAN;
                col_q   <= col_next;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_q <= '0;
            end
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col_o   = col_q;
  assign press_o = press_q;
  assign code_o  = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: builds up to MAX_DIGITS decimal digits from
// debounced key presses, holding the value both as binary and as BCD.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [7:0]  value,
  output logic [15:0] bcd,
  output logic [1:0]  digit_count,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        entry_err
);

  logic       press;
  logic [3:0] code;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk_i  (clk),
    .rst_ni (reset),
    .row_i  (row),
    .col_o  (col),
    .press_o(press),
    .code_o (code)
  );

  logic [7:0]  value_q, value_d;
  logic [11:0] bcd_q, bcd_d;
  logic [1:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        kv_q, kv_d;
  logic [3:0]  kcode_q, kcode_d;
  logic [11:0] append_val;

  // Widened so value*10+d cannot wrap before the 255 limit check.
  assign append_val = {4'b0, value_q} * 12'd10 + {8'b0, code};

  // Next entry state from the accepted key, with clear taking priority.
  always_comb begin
    value_d = value_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    err_d   = err_q;
    kv_d    = 1'b0;
    kcode_d = kcode_q;
    if (press) begin
      kv_d    = 1'b1;
      kcode_d = code;
      if (code <= 4'd9) begin
        if (count_q < 2'(MAX_DIGITS) && append_val <= 12'd255) begin
          value_d = append_val[7:0];
          bcd_d   = {bcd_q[7:0], code};
          count_d = count_q + 2'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (code == KEY_STAR) begin
        bcd_d   = bcd_q >> 4;
        value_d = value_q / 8'd10;
        if (count_q != 2'd0) count_d = count_q - 2'd1;
        err_d   = 1'b0;
      end else if (code == KEY_HASH) begin
        value_d = 8'd0;
        bcd_d   = 12'd0;
        count_d = 2'd0;
        err_d   = 1'b0;
      end
    end
    if (clear) begin
      value_d = 8'd0;
      bcd_d   = 12'd0;
      count_d = 2'd0;
      err_d   = 1'b0;
    end
  end

  // Entry registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= 8'd0;
      bcd_q   <= 12'd0;
      count_q <= 2'd0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
      kcode_q <= 4'd0;
    end else begin
      value_q <= value_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
      kcode_q <= kcode_d;
    end
  end

  assign value       = value_q;
  assign bcd         = {4'h0, bcd_q};
  assign digit_count = count_q;
  assign key_valid   = kv_q;
  assign key_code    = kcode_q;
  assign entry_err   = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad matrix model, digit-list reference model,
// expectation queue filled by stimulus and drained by a key_valid monitor.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [7:0]  value;
  logic [15:0] bcd;
  logic [1:0]  digit_count;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        entry_err;

  bit [15:0]   pressed;

  always #5 clk = ~clk;

  keypad_entry #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2),
    .MAX_DIGITS    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .row        (row),
    .col        (col),
    .value      (value),
    .bcd        (bcd),
    .digit_count(digit_count),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .entry_err  (entry_err)
  );

  // Keypad: a pressed switch at (r,c) pulls row r low while col c is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  function automatic int pos_of(int code);
    for (int i = 0; i < 16; i++) if (keymap[i] == code) return i;
    return 0;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: the entry is just the list of accepted digits.
  int digs[$];
  int m_err = 0;

  function automatic int m_value();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function automatic int m_bcd();
    int b = 0;
    foreach (digs[i]) b = b * 16 + digs[i];
    return b;
  endfunction

  function automatic void m_clear();
    digs.delete();
    m_err = 0;
  endfunction

  function automatic void m_key(int code);
    if (code <= 9) begin
      if (digs.size() < 3 && m_value() * 10 + code <= 255) digs.push_back(code);
      else m_err = 1;
    end else if (code == 14) begin
      if (digs.size() > 0) void'(digs.pop_back());
      m_err = 0;
    end else if (code == 15) begin
      m_clear();
    end
  endfunction

  typedef struct {
    int code;
    int value;
    int bcd;
    int cnt;
    int err;
  } exp_t;

  exp_t sb[$];

  function automatic void push_exp(int code);
    exp_t e;
    e.code  = code;
    e.value = m_value();
    e.bcd   = m_bcd();
    e.cnt   = digs.size();
    e.err   = m_err;
    sb.push_back(e);
  endfunction

  // Monitor: every key_valid pulse is matched against the oldest expectation.
  int   pulses = 0;
  bit   prev_kv = 1'b0;
  exp_t em;

  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      check("key_valid_single_cycle", int'(prev_kv), 0);
      check("col_one_low", $countones(~col), 1);
      if (sb.size() == 0) begin
        check("unexpected_key_valid", 1, 0);
      end else begin
        em = sb.pop_front();
        check("key_code", int'(key_code), em.code);
        check("value", int'(value), em.value);
        check("bcd", int'(bcd), em.bcd);
        check("digit_count", int'(digit_count), em.cnt);
        check("entry_err", int'(entry_err), em.err);
      end
    end
    prev_kv = key_valid;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(int code, int hold, int rel);
    m_key(code);
    push_exp(code);
    pressed[pos_of(code)] = 1'b1;
    tick(hold);
    pressed = '0;
    tick(rel);
  endtask

  task automatic check_state();
    check("idle_value", int'(value), m_value());
    check("idle_bcd", int'(bcd), m_bcd());
    check("idle_digit_count", int'(digit_count), digs.size());
    check("idle_entry_err", int'(entry_err), m_err);
  endtask

  task automatic check_reset_outputs();
    check("rst_col", int'(col), 4'b1110);
    check("rst_value", int'(value), 0);
    check("rst_bcd", int'(bcd), 0);
    check("rst_digit_count", int'(digit_count), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_entry_err", int'(entry_err), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit found;
    int code;

    reset   = 1'b0;
    clear   = 1'b0;
    pressed = '0;
    tick(5);
    check_reset_outputs();
    reset = 1'b1;
    tick(10);

    // 1, 2, 7 -> 127
    p0 = pulses;
    press_key(1, 100, 60);
    press_key(2, 100, 60);
    press_key(7, 100, 60);
    check("three_pulses", pulses - p0, 3);
    check("val_127", int'(value), 127);
    check("bcd_0127", int'(bcd), 16'h0127);
    check_state();

    // 2,5,6 rejects the 6; 5 reaches 255; 9 is rejected
    press_key(15, 100, 60);
    press_key(2, 100, 60);
    press_key(5, 100, 60);
    press_key(6, 100, 60);
    check("val_25_err", int'(entry_err), 1);
    check("val_25", int'(value), 25);
    press_key(5, 100, 60);
    check("val_255", int'(value), 255);
    press_key(9, 100, 60);
    check("val_255_kept", int'(value), 255);
    check_state();

    // 4, 2, backspace, then hash
    press_key(15, 100, 60);
    press_key(4, 100, 60);
    press_key(2, 100, 60);
    press_key(14, 100, 60);
    check("bs_bcd", int'(bcd), 16'h0004);
    check("bs_count", int'(digit_count), 1);
    press_key(15, 100, 60);
    check_state();

    // Bouncy 8 then a long stable hold: exactly one pulse
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pressed[pos_of(8)] = 1'b1;
      tick(3);
      pressed = '0;
      tick(5);
    end
    press_key(8, 320, 60);
    check("bounce_one_pulse", pulses - p0, 1);
    check("bounce_val_8", int'(value), 8);

    // Two rows low in the same column: ignored
    p0 = pulses;
    pressed = 16'h0011;
    tick(200);
    pressed = '0;
    tick(60);
    check("multirow_no_pulse", pulses - p0, 0);

    // Clear coincident with the ACCEPT of key 3
    p0 = pulses;
    pressed[pos_of(3)] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (dut.u_scan.press_o) found = 1'b1;
    end
    check("accept_seen", int'(found), 1);
    if (found) begin
      clear = 1'b1;
      m_clear();
      push_exp(3);
      @(negedge clk);
      clear = 1'b0;
    end
    tick(60);
    pressed = '0;
    tick(60);
    check("clracc_pulses", pulses - p0, 1);
    check("clracc_code", int'(key_code), 3);
    check("clracc_value", int'(value), 0);

    // Reset while holding a key; the key is accepted again afterwards
    p0 = pulses;
    m_key(5);
    push_exp(5);
    pressed[pos_of(5)] = 1'b1;
    for (int i = 0; i < 300 && pulses == p0; i++) @(negedge clk);
    check("hold_first_accept", pulses - p0, 1);
    tick(20);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    m_clear();
    p0 = pulses;
    m_key(5);
    push_exp(5);
    tick(150);
    pressed = '0;
    tick(60);
    check("reaccept_after_reset", pulses - p0, 1);
    check_state();

    // Random keys with occasional clear strobes between them
    for (int n = 0; n < 20; n++) begin
      code = int'($urandom_range(0, 15));
      press_key(code, int'($urandom_range(80, 150)), int'($urandom_range(40, 80)));
      if ($urandom_range(0, 4) == 0) begin
        clear = 1'b1;
        m_clear();
        @(negedge clk);
        clear = 1'b0;
        check_state();
      end
    end
    check_state();

    tick(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Upstream stage of the calculator datapath: scans the 4x4 matrix keypad, debounces key presses and builds up to three decimal digits.
- Presents the entered number as 8-bit binary for the arithmetic unit's operand input, and as 16-bit BCD for the output/display unit.
- Also accepts the control unit's clear strobe.

Parameters:
- SCAN_DIV, 50000, clk cycles per column step; rows are sampled on the last cycle of each step.
- DEBOUNCE_SCANS, 4, consecutive identical samples required to accept a press or a release.
- MAX_DIGITS, 3, maximum number of decimal digits held.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous active-high strobe; clears the entry (digits, value, error).
- row  in  4  keypad rows; active-low, externally pulled up.
- col  out  4  keypad column drive; active-low, exactly one bit low at a time.
- value  out  8  binary value of the entered digits (0..255).
- bcd  out  16  [15:12]=0, [11:8] hundreds, [7:4] tens, [3:0] ones.
- digit_count  out  2  number of digits entered (0..3).
- key_valid  out  1  one-cycle pulse per accepted key.
- key_code  out  4  code of the last accepted key (see map).
- entry_err  out  1  sticky flag: a digit was rejected.

Behaviour:
- Reset (reset=0 at a clk edge), values:
  - col=4'b1110, value=0, bcd=0, digit_count=0.
  - key_valid=0, key_code=0, entry_err=0.
  - FSM=SCAN, divider=0, row synchronizer=4'b1111.
- Row synchronizer: row passes through a 2-flop synchronizer before any use.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- key_code values: digits = 0..9, A..D = 10..13, '*' = 14, '#' = 15.
- FSM states:
  - SCAN: col rotates 1110->1101->1011->0111->1110 every SCAN_DIV cycles. At a sample point with exactly one row low, go to DEBOUNCE and freeze col. Zero rows low or more than one row low: keep scanning.
  - DEBOUNCE: col held. Each SCAN_DIV period, sample rows.
    - Same single-low pattern: increment count.
    - Different pattern: return to SCAN; col resumes at the next column.
    - Count reaches DEBOUNCE_SCANS: go to ACCEPT.
  - ACCEPT: lasts 1 cycle. Apply the key; next cycle go to WAIT_RELEASE.
  - WAIT_RELEASE: col held. Require DEBOUNCE_SCANS consecutive all-high samples, then go to SCAN. Any low sample restarts the count. No repeat keys are generated while a key is held.
- Key actions (registered; they take effect on the edge that ends ACCEPT):
  - key_valid pulses high in the cycle the new value/bcd/key_code first appear.
  - Digit d with digit_count<MAX_DIGITS and value*10+d<=255: shift the BCD left one digit, insert d, value=value*10+d, digit_count+1.
  - Digit that would exceed 255, or a 4th digit: nothing changes, entry_err=1, key_valid still pulses.
  - '*' (backspace): drop the ones digit (bcd>>4), value=value/10, digit_count-1 (saturates at 0), entry_err=0.
  - '#': same effect as clear.
  - A..D: only key_code updates and key_valid pulses; entry unchanged.
- Arithmetic: the value*10+d check is done at 9+ bits to avoid wrap. value never exceeds 255.
- clear input: zeroes bcd, value, digit_count and entry_err next cycle. Scan FSM is unaffected.
  - clear coincident with ACCEPT: clear wins; key_code still updates and key_valid still pulses.
- reset mid-debounce or mid-hold: FSM returns to SCAN. A still-held key is then re-detected and accepted as a new press.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum {SCAN, DEBOUNCE, ACCEPT, WAIT_RELEASE}.
  - Key-code constants KEY_STAR=14 and KEY_HASH=15.
  - The 4x4 decode table as a function (row_idx, col_idx) -> key_code.
- One sub-module, keypad_scanner: synchronizer, divider, FSM, col drive and decode. It outputs a press strobe and a code.
- The top (keypad_entry) holds the digit/BCD/binary accumulator.

Test Plan:
All directed tests use SCAN_DIV=4, DEBOUNCE_SCANS=2 and a keypad model that pulls the row low when the matching col is low.
- Press 1, 2, 7, each held ≥3 scans and then released -> three key_valid pulses; final bcd=16'h0127, value=127, digit_count=3, entry_err=0.
- Enter 2, 5, 6 -> value stays 25, bcd=16'h0025, entry_err=1. Then press 5 -> value=255. Then press 9 -> rejected, value stays 255, entry_err=1.
- Enter 4, 2, then '*' -> bcd=16'h0004, value=4, digit_count=1. Then '#' -> all zero.
- Key 8 bounces (low 1 sample, high, low) before a stable press -> exactly one key_valid, value=8. Hold 20 scans -> no further pulses.
- Rows r0 and r1 low together in col0 -> no key_valid. Assert clear in the same cycle as an ACCEPT of 3 -> value=0, key_code=3, one key_valid pulse.
- Drive reset=0 for 1 cycle while in WAIT_RELEASE -> next cycle all outputs at reset values, col=1110. The held key is then re-accepted once.
